// File: rtl/dmem_pkg.sv
// Shared encodings for the data memory controller: access sizes and FSM states.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  // Offset of the last byte touched by an access of the given size.
  function automatic logic [1:0] size_last(input logic [1:0] sz);
    unique case (sz)
      SZ_BYTE: size_last = 2'd0;
      SZ_HALF: size_last = 2'd1;
      default: size_last = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables/data and load extraction/extension.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  always_comb begin
    be_o    = '0;
    wdata_o = '0;
    rdata_o = '0;
    // Move the addressed byte lane down to bit 0 before extension.
    shifted = rword_i >> {addr_lo_i, 3'b000};
    unique case (size_i)
      SZ_BYTE: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        be_o    = 4'b0011 << addr_lo_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
      end
      SZ_WORD: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Serial byte-addressable data memory with IDLE/ACCESS/RESP handshake FSM.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned LATENCY     = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IdxW = $clog2(DEPTH_BYTES);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic              we_q, uns_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              rsp_valid_q, rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic [7:0] mem_q [DEPTH_BYTES] = '{default: 8'h00};

  logic [ADDR_W:0]   last_byte;
  logic              misalign, err;
  logic              do_access;
  logic [IdxW-1:0]   word_base;
  logic [31:0]       rword, wdata_al, rdata_al;
  logic [3:0]        be;

  // Range check is done one bit wider than the address so the top can never wrap.
  assign last_byte = {1'b0, addr_q} + {{(ADDR_W - 1){1'b0}}, size_last(size_q)};
  assign misalign  = ((size_q == SZ_HALF) && addr_q[0]) ||
                     ((size_q == SZ_WORD) && (addr_q[1:0] != 2'b00));
  assign err       = (size_q == SZ_RSVD) || misalign ||
                     (last_byte >= (ADDR_W + 1)'(DEPTH_BYTES));
  assign do_access = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign word_base = {addr_q[IdxW-1:2], 2'b00};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      rword[8*i +: 8] = mem_q[word_base + IdxW'(i)];
    end
  end

  dmem_lane_align u_align (
    .size_i     (size_q),
    .addr_lo_i  (addr_q[1:0]),
    .unsigned_i (uns_q),
    .wdata_i    (wdata_q),
    .rword_i    (rword),
    .be_o       (be),
    .wdata_o    (wdata_al),
    .rdata_o    (rdata_al)
  );

  always_ff @(posedge clk) begin
    if (rst_n && do_access && we_q && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[word_base + IdxW'(i)] <= wdata_al[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= 4'(LATENCY - 1);
            state_q <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt_q == 4'd0) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= err;
            rsp_rdata_q <= (err || we_q) ? 32'h0 : rdata_al;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed vector bench for data_memory_ctrl with LATENCY=3 plus stall/reset sequences.
module tb_data_memory_ctrl;

  localparam int unsigned Lat = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[$];

  data_memory_ctrl #(
    .DEPTH_BYTES (1024),
    .ADDR_W      (32),
    .LATENCY     (Lat)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee, input string nm);
    vec_t v;
    v.we = we; v.size = sz; v.uns = uns; v.addr = addr; v.wdata = wd;
    v.exp_rdata = er; v.exp_err = ee; v.name = nm;
    return v;
  endfunction

  // Called at a negedge; returns at a negedge with the response consumed.
  task automatic do_req(input vec_t v);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_we = v.we; req_size = v.size; req_unsigned = v.uns;
    req_addr = v.addr; req_wdata = v.wdata;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk({v.name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({v.name, " latency"}, n, Lat);
    chk({v.name, " rdata"}, rsp_rdata, v.exp_rdata);
    chk({v.name, " err"}, 32'(rsp_err), 32'(v.exp_err));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    vecs.push_back(mk(1, 2, 0, 32'h10,  32'hDEADBEEF, 32'h0,        0, "SW 0x10"));
    vecs.push_back(mk(0, 2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, "LW 0x10"));
    vecs.push_back(mk(0, 0, 1, 32'h13,  32'h0,        32'h000000DE, 0, "LBU 0x13"));
    vecs.push_back(mk(0, 0, 0, 32'h13,  32'h0,        32'hFFFFFFDE, 0, "LB 0x13"));
    vecs.push_back(mk(1, 1, 0, 32'h22,  32'h1234ABCD, 32'h0,        0, "SH 0x22"));
    vecs.push_back(mk(0, 2, 0, 32'h20,  32'h0,        32'hABCD0000, 0, "LW 0x20"));
    vecs.push_back(mk(0, 1, 0, 32'h22,  32'h0,        32'hFFFFABCD, 0, "LH 0x22"));
    vecs.push_back(mk(0, 1, 1, 32'h22,  32'h0,        32'h0000ABCD, 0, "LHU 0x22"));
    vecs.push_back(mk(0, 2, 0, 32'h06,  32'h0,        32'h0,        1, "LW 0x06 misal"));
    vecs.push_back(mk(1, 1, 0, 32'h05,  32'hFFFF,     32'h0,        1, "SH 0x05 misal"));
    vecs.push_back(mk(1, 3, 0, 32'h10,  32'h0,        32'h0,        1, "store size3"));
    vecs.push_back(mk(1, 2, 0, 32'h3FE, 32'hFFFFFFFF, 32'h0,        1, "SW 0x3FE"));
    vecs.push_back(mk(0, 2, 0, 32'h04,  32'h0,        32'h0,        0, "LW 0x04 unchanged"));
    vecs.push_back(mk(0, 2, 0, 32'h10,  32'h0,        32'hDEADBEEF, 0, "LW 0x10 unchanged"));
    vecs.push_back(mk(0, 2, 0, 32'h3FC, 32'h0,        32'h0,        0, "LW 0x3FC unchanged"));
    vecs.push_back(mk(1, 0, 0, 32'h11,  32'hFFFFFF77, 32'h0,        0, "SB 0x11"));
    vecs.push_back(mk(0, 2, 0, 32'h10,  32'h0,        32'hDEAD77EF, 0, "LW 0x10 after SB"));
    vecs.push_back(mk(0, 0, 0, 32'h11,  32'h0,        32'h00000077, 0, "LB 0x11"));
    vecs.push_back(mk(0, 1, 0, 32'h12,  32'h0,        32'hFFFFDEAD, 0, "LH 0x12"));
    vecs.push_back(mk(0, 2, 1, 32'h10,  32'h0,        32'hDEAD77EF, 0, "LW uns 0x10"));
    vecs.push_back(mk(1, 0, 0, 32'h3FF, 32'h0000005A, 32'h0,        0, "SB 0x3FF"));
    vecs.push_back(mk(0, 0, 0, 32'h3FF, 32'h0,        32'h0000005A, 0, "LB 0x3FF"));
    vecs.push_back(mk(0, 1, 0, 32'h3FE, 32'h0,        32'h00005A00, 0, "LH 0x3FE"));
    vecs.push_back(mk(1, 1, 0, 32'h3FE, 32'h00008001, 32'h0,        0, "SH 0x3FE"));
    vecs.push_back(mk(0, 1, 0, 32'h3FE, 32'h0,        32'hFFFF8001, 0, "LH 0x3FE signed"));
    vecs.push_back(mk(0, 2, 0, 32'h400, 32'h0,        32'h0,        1, "LW 0x400 range"));
    vecs.push_back(mk(1, 0, 0, 32'h400, 32'h33,       32'h0,        1, "SB 0x400 range"));
    vecs.push_back(mk(0, 0, 1, 32'h0,   32'h0,        32'h0,        0, "LBU 0x0 unchanged"));
    vecs.push_back(mk(0, 2, 0, 32'hFFFFFFFC, 32'h0,   32'h0,        1, "LW top no wrap"));

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'h0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);

    foreach (vecs[i]) do_req(vecs[i]);

    // Back-pressure: response held 5 cycles; a stray store while busy must be ignored.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
    chk("stall ready before", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_we = 1'b1; req_wdata = 32'h0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      chk("stall ready access", 32'(req_ready), 32'd0);
      @(negedge clk);
      n++;
    end
    chk("stall latency", n, Lat);
    for (int k = 0; k < 5; k++) begin
      chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall rdata", rsp_rdata, 32'hDEAD77EF);
      chk("stall err", 32'(rsp_err), 32'd0);
      chk("stall ready resp", 32'(req_ready), 32'd0);
      if (k < 4) @(negedge clk);
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("stall done rsp_valid", 32'(rsp_valid), 32'd0);
    chk("stall done ready", 32'(req_ready), 32'd1);
    do_req(mk(0, 2, 0, 32'h10, 32'h0, 32'hDEAD77EF, 0, "LW after stray"));

    // Reset in the first ACCESS cycle abandons the store.
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h40; req_wdata = 32'h11111111;
    @(negedge clk);
    req_valid = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst access ready", 32'(req_ready), 32'd1);
    chk("rst access rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst access rdata", rsp_rdata, 32'h0);
    do_req(mk(0, 2, 0, 32'h40, 32'h0, 32'h0, 0, "LW 0x40 after rst"));

    // Reset during RESP drops the response.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h10;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge clk); n++; end
    chk("rst resp seen", 32'(rsp_valid), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst resp rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst resp rdata", rsp_rdata, 32'h0);
    chk("rst resp ready", 32'(req_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/data_memory_ctrl.md
DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL use one clock and a reset that is synchronous and active-low: clk, rst_n.
REQ-002 Parameter DEPTH_BYTES, default 1024: byte capacity of the storage; SHALL be a power of two, at least 4.
REQ-003 Parameter ADDR_W, default 32: request address width.
REQ-004 Parameter LATENCY, default 1: ACCESS cycles per request; SHALL be in the range 1..15.
REQ-005 Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  controller accepts request
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved
- req_unsigned  in  1  load zero-extends when 1
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, low bytes used
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result
- rsp_err  out  1  request rejected

Function
REQ-006 The FSM SHALL have three states: IDLE, ACCESS and RESP.
REQ-007 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid && req_ready, latching we, size, unsigned, addr and wdata, and the FSM moves to ACCESS.
REQ-008 ACCESS SHALL last exactly LATENCY cycles, tracked by a down-counter, and then the FSM moves to RESP.
REQ-009 The store write and the load read SHALL occur on the clock edge leaving ACCESS, and rsp_valid SHALL rise on that same edge.
REQ-010 Total latency SHALL be LATENCY+1 cycles from the acceptance edge to the first cycle with rsp_valid=1.
REQ-011 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL hold stable until rsp_valid && rsp_ready, after which the FSM returns to IDLE.
REQ-012 Peak throughput SHALL be one request per LATENCY+2 cycles; there is no overlap between requests.
REQ-013 Byte order SHALL be little-endian: byte k of the data maps to address addr+k.
REQ-014 A byte store SHALL write 1 byte, a half store 2 bytes, and a word store 4 bytes; unaddressed bytes SHALL be unchanged.
REQ-015 Loads SHALL right-justify the data, sign-extend when req_unsigned=0 and zero-extend when req_unsigned=1; a word load ignores req_unsigned.
REQ-016 rsp_err SHALL be 1 in any of these cases:
- req_size = 3;
- a half access with addr[0] != 0;
- a word access with addr[1:0] != 0;
- addr + bytes - 1 >= DEPTH_BYTES, evaluated at full ADDR_W width with no wrap-around.
REQ-017 On an errored request the block SHALL perform no write and return rsp_rdata = 0.
REQ-018 A store response SHALL return rsp_rdata = 0.
REQ-019 A load issued after a store to the same address SHALL return the stored data, because transactions are strictly serial.
REQ-020 req_valid asserted outside IDLE SHALL be ignored; a requester holds the request until it sees req_ready.

Reset
REQ-021 When rst_n=0 at a clock edge, the block SHALL enter IDLE with rsp_valid=0, rsp_rdata=0, rsp_err=0 and the counter at 0; req_ready SHALL read 1 on the following cycle.
REQ-022 A reset during ACCESS SHALL abandon the request, and no write SHALL occur.
REQ-023 A reset during RESP SHALL drop the response.
REQ-024 Storage contents SHALL NOT be affected by reset and SHALL be zero at time zero.

Structure
REQ-025 A package dmem_pkg SHALL hold the size encodings (SZ_BYTE=0, SZ_HALF=1, SZ_WORD=2, SZ_RSVD=3) and the state enum (IDLE, ACCESS, RESP).
REQ-026 Sub-module dmem_lane_align SHALL be combinational and produce:
- per-byte write enables and the shifted store data, from size, addr[1:0] and wdata;
- the extracted and extended load value.
REQ-027 Storage SHALL be DEPTH_BYTES 8-bit entries, indexed by addr[$clog2(DEPTH_BYTES)-1:0] after the range check passes.

Verification
REQ-028 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rdata 0xDEADBEEF, err 0; LBU 0x13 -> 0x000000DE; LB 0x13 -> 0xFFFFFFDE.
REQ-029 SH addr 0x22 data 0x1234ABCD, then LW 0x20 -> 0xABCD0000 from a zeroed word; LH 0x22 -> 0xFFFFABCD; LHU 0x22 -> 0x0000ABCD.
REQ-030 LW 0x06, SH 0x05, req_size=3 and SW 0x3FE (DEPTH_BYTES=1024) -> err 1, rdata 0, and a following LW shows memory unchanged.
REQ-031 LATENCY=3, LW 0x10 accepted at cycle 0 with rsp_ready=0 for 5 cycles -> rsp_valid first at cycle 4, outputs stable until rsp_ready, req_ready=0 throughout.
REQ-032 SW 0x40 data 0x11111111, with rst_n=0 asserted in the first ACCESS cycle, then LW 0x40 after reset -> 0x00000000, with req_ready=1 and rsp_valid=0 the cycle after reset.
